// File: rtl/concat_counter.sv
// Wide free-running counter read out one OUT_WIDTH slice at a time.
// A slice-0 read captures the whole count into a snapshot, so the
// upper slices read afterwards belong to the same count value even
// while the live counter keeps advancing.
module concat_counter #(
  parameter int          WIDTH     = 64,
  parameter int          OUT_WIDTH = 32,
  parameter int unsigned STEP      = 1,
  localparam int         NSLICE    = WIDTH / OUT_WIDTH,
  localparam int         SEL_W     = (NSLICE > 2) ? $clog2(NSLICE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 rd_req,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 rd_err,
  output logic                 wrap
);

  localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH+1)'(STEP);
  localparam logic [SEL_W:0]   NSLICE_EXT = (SEL_W+1)'(NSLICE);

  logic [WIDTH-1:0]     cnt;
  logic [WIDTH-1:0]     snap;
  logic [WIDTH:0]       sum;
  logic [OUT_WIDTH-1:0] slice_data;
  logic                 sel_oob;

  // One extra bit on the sum catches the carry out of the top of cnt.
  always_comb begin
    sum = {1'b0, cnt} + STEP_EXT;
  end

  // Slice mux over the snapshot; index 0 is served from the live count.
  always_comb begin
    slice_data = '0;
    for (int i = 1; i < NSLICE; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        slice_data = snap[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
    sel_oob = ({1'b0, rd_sel} >= NSLICE_EXT);
  end

  // Live count and sticky overflow flag: load beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      cnt <= sum[WIDTH-1:0];
      if (sum[WIDTH]) begin
        wrap <= 1'b1;
      end
    end
  end

  // Read path: one-cycle latency, uses cnt as it was before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      out_valid <= rd_req;
      rd_err    <= 1'b0;
      if (rd_req) begin
        if (sel_oob) begin
          out    <= '0;
          rd_err <= 1'b1;
        end else if (rd_sel == '0) begin
          snap <= cnt;
          out  <= cnt[OUT_WIDTH-1:0];
        end else begin
          out <= slice_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_counter.sv
// Bench for concat_counter: default 64/32 instance against a reference
// model, plus a 96/32 instance for out-of-range slice reads.
module tb_concat_counter;

  localparam int W  = 64;
  localparam int OW = 32;
  localparam longint unsigned STEP_M = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0, load = 1'b0, rd_req = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          rd_sel = 1'b0;
  logic [OW-1:0] out;
  logic          out_valid, rd_err, wrap;

  logic          rst96 = 1'b1, en96 = 1'b0, load96 = 1'b0, rd_req96 = 1'b0;
  logic [95:0]   load_val96 = '0;
  logic [1:0]    rd_sel96 = '0;
  logic [OW-1:0] out96;
  logic          out_valid96, rd_err96, wrap96;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0]  m_cnt, m_snap;
  logic [OW-1:0] m_out;
  logic          m_ov, m_err, m_wrap;

  concat_counter #(.WIDTH(64), .OUT_WIDTH(32), .STEP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .rd_req(rd_req), .rd_sel(rd_sel), .out(out), .out_valid(out_valid),
    .rd_err(rd_err), .wrap(wrap)
  );

  concat_counter #(.WIDTH(96), .OUT_WIDTH(32), .STEP(1)) dut96 (
    .clk(clk), .rst(rst96), .en(en96), .load(load96), .load_val(load_val96),
    .rd_req(rd_req96), .rd_sel(rd_sel96), .out(out96), .out_valid(out_valid96),
    .rd_err(rd_err96), .wrap(wrap96)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // One clock edge: advance the model with the inputs in force, then
  // settle 1 time unit past the edge before anything is checked.
  task automatic tick();
    logic [W-1:0] maxv;
    maxv = '1;
    @(posedge clk);
    if (rst) begin
      m_cnt = '0; m_snap = '0; m_out = '0; m_ov = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    end else begin
      m_ov  = rd_req;
      m_err = 1'b0;
      if (rd_req) begin
        if (rd_sel == 1'b0) begin
          m_snap = m_cnt;
          m_out  = m_cnt[OW-1:0];
        end else begin
          m_out = m_snap[int'(rd_sel)*OW +: OW];
        end
      end
      if (load) begin
        m_cnt  = load_val;
        m_wrap = 1'b0;
      end else if (en) begin
        if (m_cnt > maxv - W'(STEP_M)) m_wrap = 1'b1;
        m_cnt = m_cnt + W'(STEP_M);
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; en = 1'b0; load = 1'b0; rd_req = 1'b0; rd_sel = 1'b0; load_val = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; load_val = 64'd77; en = 1'b1; rd_req = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd0 || out_valid !== 1'b0 || rd_err !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h valid=%b err=%b wrap=%b, required 0/0/0/0", out, out_valid, rd_err, wrap);
    end
    idle();
    rd_req = 1'b1; rd_sel = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_slice1_no_snap: out=%h valid=%b, required 0 valid 1", out, out_valid);
    end
    idle();
  endtask

  task automatic test_increment();
    rst = 1'b1; tick(); idle();
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0; rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    n_tests++;
    if (out !== 32'd5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL increment_read: out=%0d valid=%b, required 5 valid 1", out, out_valid);
    end
    idle();
    tick();
    n_tests++;
    if (out !== 32'd5 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL increment_hold: out=%0d valid=%b, required 5 valid 0", out, out_valid);
    end
  endtask

  task automatic test_coherent();
    idle();
    load = 1'b1; load_val = 64'h0000_0001_FFFF_FFFF;
    tick();
    load = 1'b0; en = 1'b1; rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    n_tests++;
    if (out !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coherent_lo: out=%h valid=%b, required ffffffff valid 1", out, out_valid);
    end
    rd_sel = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'h0000_0001 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coherent_hi: out=%h valid=%b, required 00000001 valid 1", out, out_valid);
    end
    idle();
  endtask

  task automatic test_wrap();
    idle();
    load = 1'b1; load_val = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_after_load: wrap=%b, required 0", wrap);
    end
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0; rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    n_tests++;
    if (wrap !== 1'b1 || out !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_set: wrap=%b lo=%h, required 1 and 0", wrap, out);
    end
    rd_sel = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt_hi: out=%h, required 0", out);
    end
    rd_req = 1'b0; en = 1'b1;
    repeat (10) tick();
    en = 1'b0; rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    n_tests++;
    if (wrap !== 1'b1 || out !== 32'd10) begin
      n_fail++;
      $display("FAIL wrap_sticky: wrap=%b out=%0d, required 1 and 10", wrap, out);
    end
    rd_req = 1'b0; load = 1'b1; load_val = '0;
    tick();
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear_load: wrap=%b, required 0", wrap);
    end
    idle();
  endtask

  task automatic test_priority();
    idle();
    load = 1'b1; en = 1'b1; load_val = 64'd100;
    tick();
    idle(); rd_req = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd100) begin
      n_fail++;
      $display("FAIL prio_load_over_en: out=%0d, required 100", out);
    end
    rd_req = 1'b0; rst = 1'b1; load = 1'b1; load_val = 64'd55;
    tick();
    idle(); rd_req = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_rst_over_load: out=%0d valid=%b, required 0 valid 1", out, out_valid);
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    idle();
    load = 1'b1; load_val = 64'h1234_5678_9ABC_DEF0;
    tick();
    load = 1'b0; rd_req = 1'b1;
    tick();
    rst = 1'b1; rd_req = 1'b1;
    tick();
    n_tests++;
    if (out !== 32'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: out=%h valid=%b, required 0 valid 0", out, out_valid);
    end
    idle();
  endtask

  task automatic test_range_err();
    rst96 = 1'b1;
    tick();
    rst96 = 1'b0; load96 = 1'b1; load_val96 = 96'hAAAA_0003_BBBB_0002_CCCC_0001;
    tick();
    load96 = 1'b0; rd_req96 = 1'b1; rd_sel96 = 2'd0;
    tick();
    n_tests++;
    if (out96 !== 32'hCCCC_0001 || out_valid96 !== 1'b1 || rd_err96 !== 1'b0) begin
      n_fail++;
      $display("FAIL w96_slice0: out=%h valid=%b err=%b, required cccc0001/1/0", out96, out_valid96, rd_err96);
    end
    rd_sel96 = 2'd2;
    tick();
    n_tests++;
    if (out96 !== 32'hAAAA_0003 || rd_err96 !== 1'b0) begin
      n_fail++;
      $display("FAIL w96_slice2: out=%h err=%b, required aaaa0003/0", out96, rd_err96);
    end
    rd_sel96 = 2'd3;
    tick();
    n_tests++;
    if (out96 !== 32'd0 || out_valid96 !== 1'b1 || rd_err96 !== 1'b1) begin
      n_fail++;
      $display("FAIL w96_oob: out=%h valid=%b err=%b, required 0/1/1", out96, out_valid96, rd_err96);
    end
    rd_req96 = 1'b0;
    tick();
    n_tests++;
    if (out96 !== 32'd0 || out_valid96 !== 1'b0 || rd_err96 !== 1'b0) begin
      n_fail++;
      $display("FAIL w96_oob_pulse: out=%h valid=%b err=%b, required 0/0/0", out96, out_valid96, rd_err96);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    load = 1'b1; load_val = 64'h0000_0007_FFFF_FFFD;
    tick();
    load = 1'b0; en = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_sel = i[0];
      tick();
      n_tests++;
      if (out !== m_out || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: out=%h valid=%b, required %h valid 1", i, out, out_valid, m_out);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      rd_req   = ($urandom_range(0, 2) != 0);
      rd_sel   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       load_val = {$urandom, $urandom};
        1:       load_val = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: load_val = {32'($urandom_range(0, 3)), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))};
      endcase
      tick();
      n_tests++;
      if (out !== m_out || out_valid !== m_ov || rd_err !== m_err || wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%h valid=%b err=%b wrap=%b, required %h/%b/%b/%b",
                 i, out, out_valid, rd_err, wrap, m_out, m_ov, m_err, m_wrap);
      end
    end
    idle();
  endtask

  initial begin
    m_cnt = '0; m_snap = '0; m_out = '0; m_ov = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    #1;
    test_reset();
    test_increment();
    test_coherent();
    test_wrap();
    test_priority();
    test_reset_mid_read();
    test_range_err();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
